// File: rtl/bs_input_chain.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | bs_input_chain : input boundary-scan register chain, shift, update.      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module bs_input_chain #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] UPD_RESET = {WIDTH{1'b0}}
) (
  input  logic                       TCK,
  input  logic                       TRST,
  input  logic [WIDTH-1:0]           InputPin,
  input  logic                       FromPreviousBSCell,
  input  logic                       CaptureDR,
  input  logic                       ShiftDR,
  input  logic                       UpdateDR,
  input  logic                       TestMode,
  output logic                       ToNextBSCell,
  output logic [WIDTH-1:0]           ToCore,
  output logic [$clog2(WIDTH+1)-1:0] ShiftCount,
  output logic                       ChainLoaded
);

  localparam int            CW     = $clog2(WIDTH+1);
  localparam logic [CW-1:0] C_FULL = CW'(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] upd_q, upd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tdo_q, tdo_d;

  // Strobe priority: capture over shift over update.
  always_comb begin
    sr_d  = sr_q;
    upd_d = upd_q;
    cnt_d = cnt_q;
    if (CaptureDR) begin
      sr_d  = InputPin;
      cnt_d = '0;
    end else if (ShiftDR) begin
      sr_d = {FromPreviousBSCell, sr_q[WIDTH-1:1]};
      if (cnt_q != C_FULL) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (UpdateDR) begin
      upd_d = sr_q;
    end
  end

  always_comb begin
    tdo_d = tdo_q;
    if (ShiftDR) begin
      tdo_d = sr_q[0];
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      sr_q  <= '0;
      upd_q <= UPD_RESET;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      upd_q <= upd_d;
      cnt_q <= cnt_d;
    end
  end

  // Serial output retimed on the falling edge so the next cell samples a stable bit.
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      tdo_q <= 1'b0;
    end else begin
      tdo_q <= tdo_d;
    end
  end

  assign ToNextBSCell = tdo_q;
  assign ToCore       = TestMode ? upd_q : InputPin;
  assign ShiftCount   = cnt_q;
  assign ChainLoaded  = (cnt_q == C_FULL);

endmodule
`default_nettype wire

// File: tb/tb_bs_input_chain.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for bs_input_chain (WIDTH=4): directed vector table, reset
// sequences and randomized traffic against a queue-based reference model.
module tb_bs_input_chain;

  localparam int W = 4;

  logic         TCK = 1'b0;
  logic         TRST;
  logic [W-1:0] InputPin;
  logic         FromPreviousBSCell;
  logic         CaptureDR;
  logic         ShiftDR;
  logic         UpdateDR;
  logic         TestMode;
  logic         ToNextBSCell;
  logic [W-1:0] ToCore;
  logic [2:0]   ShiftCount;
  logic         ChainLoaded;

  int n_checks = 0;
  int n_errors = 0;

  bs_input_chain #(.WIDTH(W), .UPD_RESET(4'b0000)) dut (
    .TCK(TCK), .TRST(TRST), .InputPin(InputPin),
    .FromPreviousBSCell(FromPreviousBSCell), .CaptureDR(CaptureDR),
    .ShiftDR(ShiftDR), .UpdateDR(UpdateDR), .TestMode(TestMode),
    .ToNextBSCell(ToNextBSCell), .ToCore(ToCore),
    .ShiftCount(ShiftCount), .ChainLoaded(ChainLoaded)
  );

  always #5 TCK = ~TCK;

  // Reference model: sr_m[0] is the next bit to leave the chain.
  bit         sr_m[$];
  logic [3:0] upd_m;
  int         cnt_m;
  logic       tdo_m;

  function automatic void model_reset();
    sr_m = {};
    for (int i = 0; i < W; i++) sr_m.push_back(1'b0);
    upd_m = 4'b0000;
    cnt_m = 0;
    tdo_m = 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered and left at posedge+1; inputs held until the next posedge+1.
  task automatic cycle(input logic cap, input logic sh, input logic up, input logic din,
                       input logic [3:0] pins, input logic tm);
    CaptureDR = cap; ShiftDR = sh; UpdateDR = up;
    FromPreviousBSCell = din; InputPin = pins; TestMode = tm;
    @(negedge TCK); #1;
    if (sh) tdo_m = sr_m[0];
    chk("model_tdo", {31'd0, ToNextBSCell}, {31'd0, tdo_m});
    @(posedge TCK);
    if (cap) begin
      sr_m = {};
      for (int i = 0; i < W; i++) sr_m.push_back(pins[i]);
      cnt_m = 0;
    end else if (sh) begin
      sr_m.push_back(din);
      void'(sr_m.pop_front());
      cnt_m = (cnt_m + 1 > W) ? W : cnt_m + 1;
    end else if (up) begin
      for (int i = 0; i < W; i++) upd_m[i] = sr_m[i];
    end
    #1;
    chk("model_cnt", {29'd0, ShiftCount}, cnt_m);
    chk("model_loaded", {31'd0, ChainLoaded}, {31'd0, (cnt_m == W)});
    chk("model_tocore", {28'd0, ToCore}, {28'd0, (tm ? upd_m : pins)});
  endtask

  // Asynchronous reset pulse strictly between clock edges.
  task automatic async_reset();
    #1 TRST = 1'b0;
    #1;
    model_reset();
    chk("rst_tdo", {31'd0, ToNextBSCell}, 32'd0);
    chk("rst_cnt", {29'd0, ShiftCount}, 32'd0);
    chk("rst_loaded", {31'd0, ChainLoaded}, 32'd0);
    chk("rst_tocore", {28'd0, ToCore}, {28'd0, (TestMode ? 4'b0000 : InputPin)});
    #1 TRST = 1'b1;
  endtask

  typedef struct {
    logic       cap, sh, up, din;
    logic [3:0] pins;
    logic       tm;
    logic       tdo;
    int         cnt;
    logic       ld;
    logic [3:0] tc;
  } vec_t;

  vec_t tbl[33];

  function automatic vec_t mk(logic cap, logic sh, logic up, logic din, logic [3:0] pins,
                              logic tm, logic tdo, int cnt, logic ld, logic [3:0] tc);
    vec_t v;
    v.cap = cap; v.sh = sh; v.up = up; v.din = din; v.pins = pins; v.tm = tm;
    v.tdo = tdo; v.cnt = cnt; v.ld = ld; v.tc = tc;
    return v;
  endfunction

  initial begin
    //            cap sh up din pins    tm  tdo cnt ld tocore
    tbl[0]  = mk(1, 0, 0, 0, 4'b1011, 0, 0, 0, 0, 4'b1011);
    tbl[1]  = mk(0, 1, 0, 0, 4'b1011, 0, 1, 1, 0, 4'b1011);
    tbl[2]  = mk(0, 1, 0, 0, 4'b1011, 0, 1, 2, 0, 4'b1011);
    tbl[3]  = mk(0, 1, 0, 0, 4'b1011, 0, 0, 3, 0, 4'b1011);
    tbl[4]  = mk(0, 1, 0, 0, 4'b1011, 0, 1, 4, 1, 4'b1011);
    tbl[5]  = mk(0, 1, 0, 0, 4'b0000, 0, 0, 4, 1, 4'b0000);
    tbl[6]  = mk(0, 1, 0, 1, 4'b0000, 0, 0, 4, 1, 4'b0000);
    tbl[7]  = mk(0, 1, 0, 1, 4'b0000, 0, 0, 4, 1, 4'b0000);
    tbl[8]  = mk(0, 1, 0, 0, 4'b0000, 0, 0, 4, 1, 4'b0000);
    tbl[9]  = mk(0, 0, 1, 0, 4'b0000, 1, 0, 4, 1, 4'b0110);
    tbl[10] = mk(0, 0, 0, 0, 4'b1010, 0, 0, 4, 1, 4'b1010);
    tbl[11] = mk(1, 1, 0, 0, 4'b1100, 0, 0, 0, 0, 4'b1100);
    tbl[12] = mk(0, 1, 1, 1, 4'b0000, 1, 0, 1, 0, 4'b0110);
    tbl[13] = mk(0, 1, 0, 0, 4'b0000, 1, 0, 2, 0, 4'b0110);
    tbl[14] = mk(0, 1, 0, 0, 4'b0000, 1, 1, 3, 0, 4'b0110);
    tbl[15] = mk(0, 1, 0, 0, 4'b0000, 1, 1, 4, 1, 4'b0110);
    tbl[16] = mk(0, 1, 0, 0, 4'b0000, 1, 1, 4, 1, 4'b0110);
    tbl[17] = mk(1, 0, 0, 0, 4'b0101, 0, 1, 0, 0, 4'b0101);
    tbl[18] = mk(0, 1, 0, 1, 4'b0101, 0, 1, 1, 0, 4'b0101);
    tbl[19] = mk(0, 1, 0, 0, 4'b0101, 0, 0, 2, 0, 4'b0101);
    tbl[20] = mk(0, 1, 0, 0, 4'b0101, 0, 1, 3, 0, 4'b0101);
    tbl[21] = mk(0, 1, 0, 0, 4'b0101, 0, 0, 4, 1, 4'b0101);
    tbl[22] = mk(0, 1, 0, 0, 4'b0101, 0, 1, 4, 1, 4'b0101);
    tbl[23] = mk(0, 1, 0, 0, 4'b0101, 0, 0, 4, 1, 4'b0101);
    tbl[24] = mk(0, 1, 0, 1, 4'b0000, 0, 0, 4, 1, 4'b0000);
    tbl[25] = mk(0, 1, 0, 0, 4'b0000, 0, 0, 4, 1, 4'b0000);
    tbl[26] = mk(0, 1, 0, 0, 4'b0000, 0, 0, 4, 1, 4'b0000);
    tbl[27] = mk(0, 1, 0, 1, 4'b0000, 0, 0, 4, 1, 4'b0000);
    tbl[28] = mk(0, 0, 1, 0, 4'b0000, 1, 0, 4, 1, 4'b1001);
    tbl[29] = mk(1, 0, 0, 0, 4'b0110, 1, 0, 0, 0, 4'b1001);
    tbl[30] = mk(0, 1, 0, 1, 4'b1111, 1, 0, 1, 0, 4'b1001);
    tbl[31] = mk(0, 1, 0, 0, 4'b1111, 1, 1, 2, 0, 4'b1001);
    tbl[32] = mk(1, 0, 1, 0, 4'b0000, 1, 1, 0, 0, 4'b1001);

    TRST = 1'b0; InputPin = 4'b1111; FromPreviousBSCell = 1'b0;
    CaptureDR = 1'b0; ShiftDR = 1'b0; UpdateDR = 1'b0; TestMode = 1'b1;
    model_reset();
    #2;
    chk("init_tdo", {31'd0, ToNextBSCell}, 32'd0);
    chk("init_cnt", {29'd0, ShiftCount}, 32'd0);
    chk("init_tocore", {28'd0, ToCore}, 32'd0);
    #1 TRST = 1'b1;
    @(posedge TCK); #1;

    foreach (tbl[i]) begin
      cycle(tbl[i].cap, tbl[i].sh, tbl[i].up, tbl[i].din, tbl[i].pins, tbl[i].tm);
      chk($sformatf("vec%0d_tdo", i), {31'd0, ToNextBSCell}, {31'd0, tbl[i].tdo});
      chk($sformatf("vec%0d_cnt", i), {29'd0, ShiftCount}, tbl[i].cnt);
      chk($sformatf("vec%0d_ld", i), {31'd0, ChainLoaded}, {31'd0, tbl[i].ld});
      chk($sformatf("vec%0d_tocore", i), {28'd0, ToCore}, {28'd0, tbl[i].tc});
    end

    // TestMode switching takes effect with no clock edge.
    #1 TestMode = 1'b0; InputPin = 4'b0011;
    #1 chk("tm0_tocore", {28'd0, ToCore}, 32'h3);
    TestMode = 1'b1;
    #1 chk("tm1_tocore", {28'd0, ToCore}, 32'h9);
    @(posedge TCK); #1;

    // Reset in the middle of a shift burst, then confirm nothing survives.
    cycle(1, 0, 0, 0, 4'b1111, 1);
    cycle(0, 1, 0, 1, 4'b1111, 1);
    cycle(0, 1, 0, 1, 4'b1111, 1);
    chk("pre_rst_tdo", {31'd0, ToNextBSCell}, 32'd1);
    chk("pre_rst_cnt", {29'd0, ShiftCount}, 32'd2);
    async_reset();
    for (int i = 0; i < W + 1; i++) cycle(0, 1, 0, 0, 4'b1111, 1);
    chk("post_rst_tdo", {31'd0, ToNextBSCell}, 32'd0);
    cycle(0, 0, 1, 0, 4'b1111, 1);
    chk("post_rst_upd", {28'd0, ToCore}, 32'd0);

    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 25) async_reset();
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
